// File: rtl/video_dnn_pkg.sv
// Shared width helpers for the binary-net class stages.
// Pure constants and constant functions; no logic.
package video_dnn_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int count_width(input int channel_num);
    return clog2(channel_num + 1);
  endfunction

  function automatic int class_width(input int num_class);
    return clog2(num_class + 1);
  endfunction

  // Index one past the last real class marks "no confident class".
  function automatic int class_none(input int num_class);
    return num_class;
  endfunction

endpackage

// File: rtl/video_dnn_popcount.sv
// N-bit population count.
// Combinational, zero latency; no flow control.
module video_dnn_popcount #(
  parameter int N     = 7,
  parameter int OUT_W = 3
) (
  input  logic [N-1:0]     in_dat,
  output logic [OUT_W-1:0] cnt_dat
);

  always_comb begin
    cnt_dat = '0;
    for (int i = 0; i < N; i++) begin
      cnt_dat = cnt_dat + OUT_W'(in_dat[i]);
    end
  end

endmodule

// File: rtl/video_dnn_class_argmax.sv
// Per-pixel class vote popcount, argmax and confidence threshold; 3-cycle latency.
// Whole pipeline stalls together when the output is held; VIDEO_DNN_CLASS_ARGMAX_HIST_EN adds a per-frame histogram.
module video_dnn_class_argmax
  import video_dnn_pkg::*;
#(
  parameter int NUM_CLASS   = 10,
  parameter int CHANNEL_NUM = 7,
  parameter int COUNT_WIDTH = count_width(CHANNEL_NUM),
  parameter int CLASS_WIDTH = class_width(NUM_CLASS),
  parameter int TUSER_WIDTH = 1,
  parameter int HIST_WIDTH  = 20,
  localparam int TDATA_WIDTH = NUM_CLASS * CHANNEL_NUM
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cke,
  input  logic [COUNT_WIDTH-1:0]              param_threshold,
  input  logic [TUSER_WIDTH-1:0]              s_axi4s_tuser,
  input  logic                                s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0]              s_axi4s_tdata,
  input  logic                                s_axi4s_tvalid,
  output logic                                s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]              m_axi4s_tuser,
  output logic                                m_axi4s_tlast,
  output logic [CLASS_WIDTH-1:0]              m_axi4s_tclass,
  output logic [COUNT_WIDTH-1:0]              m_axi4s_tmax,
  output logic [NUM_CLASS*COUNT_WIDTH-1:0]    m_axi4s_tcount,
  output logic                                m_axi4s_tvalid,
  input  logic                                m_axi4s_tready,
  output logic [(NUM_CLASS+1)*HIST_WIDTH-1:0] m_hist_data,
  output logic                                m_hist_valid
);

  localparam logic [CLASS_WIDTH-1:0] CLASS_NONE = CLASS_WIDTH'(class_none(NUM_CLASS));

  logic adv;
  assign adv            = cke & (~m_axi4s_tvalid | m_axi4s_tready);
  assign s_axi4s_tready = adv;

  logic [NUM_CLASS-1:0][COUNT_WIDTH-1:0] pop_cnt;

  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_cls
    logic [CHANNEL_NUM-1:0] votes;
    for (genvar ch = 0; ch < CHANNEL_NUM; ch++) begin : g_ch
      assign votes[ch] = s_axi4s_tdata[ch*NUM_CLASS + c];
    end
    video_dnn_popcount #(
      .N     (CHANNEL_NUM),
      .OUT_W (COUNT_WIDTH)
    ) u_popcount (
      .in_dat  (votes),
      .cnt_dat (pop_cnt[c])
    );
  end

  logic                                  s1_vld;
  logic [TUSER_WIDTH-1:0]                s1_user;
  logic                                  s1_last;
  logic [NUM_CLASS-1:0][COUNT_WIDTH-1:0] s1_cnt;

  logic                                  s2_vld;
  logic [TUSER_WIDTH-1:0]                s2_user;
  logic                                  s2_last;
  logic [NUM_CLASS-1:0][COUNT_WIDTH-1:0] s2_cnt;
  logic [CLASS_WIDTH-1:0]                s2_cls;
  logic [COUNT_WIDTH-1:0]                s2_max;

  logic [CLASS_WIDTH-1:0] am_cls;
  logic [COUNT_WIDTH-1:0] am_max;

  // Strict '>' while scanning upward keeps the lowest index on ties.
  always_comb begin
    am_cls = '0;
    am_max = s1_cnt[0];
    for (int i = 1; i < NUM_CLASS; i++) begin
      if (s1_cnt[i] > am_max) begin
        am_max = s1_cnt[i];
        am_cls = CLASS_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld         <= 1'b0;
      s1_user        <= '0;
      s1_last        <= 1'b0;
      s1_cnt         <= '0;
      s2_vld         <= 1'b0;
      s2_user        <= '0;
      s2_last        <= 1'b0;
      s2_cnt         <= '0;
      s2_cls         <= '0;
      s2_max         <= '0;
      m_axi4s_tvalid <= 1'b0;
      m_axi4s_tuser  <= '0;
      m_axi4s_tlast  <= 1'b0;
      m_axi4s_tclass <= '0;
      m_axi4s_tmax   <= '0;
      m_axi4s_tcount <= '0;
    end else if (adv) begin
      s1_vld         <= s_axi4s_tvalid;
      s1_user        <= s_axi4s_tuser;
      s1_last        <= s_axi4s_tlast;
      s1_cnt         <= pop_cnt;
      s2_vld         <= s1_vld;
      s2_user        <= s1_user;
      s2_last        <= s1_last;
      s2_cnt         <= s1_cnt;
      s2_cls         <= am_cls;
      s2_max         <= am_max;
      m_axi4s_tvalid <= s2_vld;
      m_axi4s_tuser  <= s2_user;
      m_axi4s_tlast  <= s2_last;
      m_axi4s_tclass <= (s2_max < param_threshold) ? CLASS_NONE : s2_cls;
      m_axi4s_tmax   <= s2_max;
      m_axi4s_tcount <= s2_cnt;
    end
  end

`ifdef VIDEO_DNN_CLASS_ARGMAX_HIST_EN
  logic [NUM_CLASS:0][HIST_WIDTH-1:0] hist_cnt;
  logic                               out_xfer;
  assign out_xfer = cke & m_axi4s_tvalid & m_axi4s_tready;

  // A frame-start beat closes the previous frame and is the first count of the new one.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_cnt     <= '0;
      m_hist_data  <= '0;
      m_hist_valid <= 1'b0;
    end else if (cke) begin
      m_hist_valid <= 1'b0;
      if (out_xfer) begin
        if (m_axi4s_tuser[0]) begin
          m_hist_data  <= hist_cnt;
          m_hist_valid <= 1'b1;
          for (int k = 0; k <= NUM_CLASS; k++) begin
            hist_cnt[k] <= (k == int'(m_axi4s_tclass)) ? HIST_WIDTH'(1) : '0;
          end
        end else begin
          for (int k = 0; k <= NUM_CLASS; k++) begin
            if (k == int'(m_axi4s_tclass) && hist_cnt[k] != '1) begin
              hist_cnt[k] <= hist_cnt[k] + HIST_WIDTH'(1);
            end
          end
        end
      end
    end
  end
`else
  assign m_hist_data  = '0;
  assign m_hist_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_dnn_class_argmax.sv
// Directed bench for video_dnn_class_argmax: latency, argmax/tie/threshold, backpressure, histogram.
module tb_video_dnn_class_argmax;

  localparam int NC = 10;
  localparam int CN = 7;
  localparam int CW = 3;
  localparam int KW = 4;
  localparam int HW = 20;
  localparam int TW = NC * CN;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  cke;
  logic [CW-1:0]         param_threshold;
  logic [0:0]            s_axi4s_tuser;
  logic                  s_axi4s_tlast;
  logic [TW-1:0]         s_axi4s_tdata;
  logic                  s_axi4s_tvalid;
  logic                  s_axi4s_tready;
  logic [0:0]            m_axi4s_tuser;
  logic                  m_axi4s_tlast;
  logic [KW-1:0]         m_axi4s_tclass;
  logic [CW-1:0]         m_axi4s_tmax;
  logic [NC*CW-1:0]      m_axi4s_tcount;
  logic                  m_axi4s_tvalid;
  logic                  m_axi4s_tready;
  logic [(NC+1)*HW-1:0]  m_hist_data;
  logic                  m_hist_valid;

  video_dnn_class_argmax dut (
    .clk             (clk),
    .reset           (reset),
    .cke             (cke),
    .param_threshold (param_threshold),
    .s_axi4s_tuser   (s_axi4s_tuser),
    .s_axi4s_tlast   (s_axi4s_tlast),
    .s_axi4s_tdata   (s_axi4s_tdata),
    .s_axi4s_tvalid  (s_axi4s_tvalid),
    .s_axi4s_tready  (s_axi4s_tready),
    .m_axi4s_tuser   (m_axi4s_tuser),
    .m_axi4s_tlast   (m_axi4s_tlast),
    .m_axi4s_tclass  (m_axi4s_tclass),
    .m_axi4s_tmax    (m_axi4s_tmax),
    .m_axi4s_tcount  (m_axi4s_tcount),
    .m_axi4s_tvalid  (m_axi4s_tvalid),
    .m_axi4s_tready  (m_axi4s_tready),
    .m_hist_data     (m_hist_data),
    .m_hist_valid    (m_hist_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sets class cls in channels 0..n-1 on top of base.
  function automatic logic [TW-1:0] votes(input logic [TW-1:0] base, input int cls, input int n);
    logic [TW-1:0] d;
    d = base;
    for (int ch = 0; ch < n; ch++) d[ch*NC + cls] = 1'b1;
    return d;
  endfunction

  // Presents one beat, then waits (bounded) until it shows up on the output.
  task automatic send_beat(input logic [TW-1:0] d, input logic u, input logic l, output int lat);
    s_axi4s_tdata  = d;
    s_axi4s_tuser  = u;
    s_axi4s_tlast  = l;
    s_axi4s_tvalid = 1'b1;
    tick();
    s_axi4s_tvalid = 1'b0;
    lat = 1;
    while (!m_axi4s_tvalid && lat < 10) begin
      tick();
      lat++;
    end
    if (!m_axi4s_tvalid) check("beat_timeout", 1'b0, 1'b1);
  endtask

  logic [TW-1:0]        d;
  logic [TW-1:0]        zero_d;
  logic [(NC+1)*HW-1:0] exp_h;
  logic [15:0]          rdy_pat;
  logic [63:0]          held_val;
  logic                 held;
  logic                 seen_vld;
  int                   lat;
  int                   sent;
  int                   rcvd;
  int                   exp_n;
  int                   exp_c;

  initial begin
    zero_d          = '0;
    reset           = 1'b1;
    cke             = 1'b1;
    param_threshold = 3'd4;
    m_axi4s_tready  = 1'b1;
    s_axi4s_tuser   = 1'b1;
    s_axi4s_tlast   = 1'b0;
    s_axi4s_tdata   = votes(zero_d, 3, 7);
    s_axi4s_tvalid  = 1'b1;

    // Reset held 3 cycles with input traffic present.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_tvalid", m_axi4s_tvalid, 1'b0);
      check("rst_hist_valid", m_hist_valid, 1'b0);
    end
    check("rst_tclass", m_axi4s_tclass, '0);
    reset = 1'b0;
    #1;
    check("tready_after_rst", s_axi4s_tready, 1'b1);

    // Class 3 in all channels, latency must be exactly 3.
    tick();
    s_axi4s_tvalid = 1'b0;
    check("lat_c1", m_axi4s_tvalid, 1'b0);
    tick();
    check("lat_c2", m_axi4s_tvalid, 1'b0);
    tick();
    check("lat_c3", m_axi4s_tvalid, 1'b1);
    check("t2_class", m_axi4s_tclass, 4'd3);
    check("t2_max", m_axi4s_tmax, 3'd7);
    check("t2_count", m_axi4s_tcount, 30'h0000_0E00);
    check("t2_user", m_axi4s_tuser, 1'b1);
    tick();
`ifdef VIDEO_DNN_CLASS_ARGMAX_HIST_EN
    check("hist_first_valid", m_hist_valid, 1'b1);
    check("hist_first_zero", m_hist_data, '0);
`else
    check("hist_tied_valid", m_hist_valid, 1'b0);
    check("hist_tied_data", m_hist_data, '0);
`endif
    check("t2_drained", m_axi4s_tvalid, 1'b0);

    // Tie between classes 2 and 5 resolves to the lower index.
    d = votes(votes(zero_d, 2, 5), 5, 5);
    send_beat(d, 1'b0, 1'b1, lat);
    check("t3_lat", lat, 3);
    check("t3_class", m_axi4s_tclass, 4'd2);
    check("t3_max", m_axi4s_tmax, 3'd5);
    check("t3_count", m_axi4s_tcount, 30'h0002_8140);
    check("t3_last", m_axi4s_tlast, 1'b1);

    d = votes(votes(zero_d, 9, 6), 0, 6);
    send_beat(d, 1'b0, 1'b0, lat);
    check("tie_0_9_class", m_axi4s_tclass, 4'd0);
    check("tie_0_9_max", m_axi4s_tmax, 3'd6);

    // Below threshold reports "none" but keeps the counts.
    d = votes(votes(zero_d, 8, 3), 1, 2);
    send_beat(d, 1'b0, 1'b0, lat);
    check("t4_class_none", m_axi4s_tclass, 4'd10);
    check("t4_max", m_axi4s_tmax, 3'd3);
    check("t4_count", m_axi4s_tcount, 30'h0300_0010);
    param_threshold = 3'd3;
    send_beat(d, 1'b0, 1'b0, lat);
    check("t4_thr_eq", m_axi4s_tclass, 4'd8);
    param_threshold = 3'd0;
    send_beat(d, 1'b0, 1'b0, lat);
    check("t4_thr0", m_axi4s_tclass, 4'd8);
    send_beat(zero_d, 1'b0, 1'b0, lat);
    check("zero_thr0_class", m_axi4s_tclass, 4'd0);
    check("zero_thr0_max", m_axi4s_tmax, 3'd0);
    param_threshold = 3'd4;
    send_beat(zero_d, 1'b0, 1'b0, lat);
    check("zero_thr4_class", m_axi4s_tclass, 4'd10);

    // cke low freezes a pending output and blocks the input.
    cke = 1'b0;
    #1;
    check("cke0_tready", s_axi4s_tready, 1'b0);
    tick();
    tick();
    check("cke0_tvalid_held", m_axi4s_tvalid, 1'b1);
    check("cke0_class_held", m_axi4s_tclass, 4'd10);
    cke = 1'b1;
    tick();
    check("cke1_consumed", m_axi4s_tvalid, 1'b0);

    // Streaming under backpressure; beat k carries class k%10 with k%7+1 votes.
    rdy_pat  = 16'b1011_0110_1101_0011;
    sent     = 0;
    rcvd     = 0;
    held     = 1'b0;
    held_val = '0;
    for (int cyc = 0; cyc < 300 && rcvd < 20; cyc++) begin
      m_axi4s_tready = rdy_pat[cyc % 16];
      if (sent < 20) begin
        s_axi4s_tvalid = (cyc % 7 != 3);
        s_axi4s_tdata  = votes(zero_d, sent % 10, sent % 7 + 1);
        s_axi4s_tuser  = (sent % 10 == 0);
        s_axi4s_tlast  = (sent % 5 == 4);
      end else begin
        s_axi4s_tvalid = 1'b0;
      end
      #1;
      if (held) begin
        check("stall_stable", {25'd0, m_axi4s_tclass, m_axi4s_tmax, m_axi4s_tcount,
                               m_axi4s_tuser, m_axi4s_tlast}, held_val);
      end
      if (m_axi4s_tvalid && m_axi4s_tready) begin
        exp_n = rcvd % 7 + 1;
        exp_c = (exp_n >= 4) ? rcvd % 10 : 10;
        check("strm_class", m_axi4s_tclass, exp_c[KW-1:0]);
        check("strm_max", m_axi4s_tmax, exp_n[CW-1:0]);
        check("strm_user", m_axi4s_tuser, (rcvd % 10 == 0));
        check("strm_last", m_axi4s_tlast, (rcvd % 5 == 4));
        rcvd++;
      end
      held     = m_axi4s_tvalid && !m_axi4s_tready;
      held_val = {25'd0, m_axi4s_tclass, m_axi4s_tmax, m_axi4s_tcount, m_axi4s_tuser, m_axi4s_tlast};
      if (s_axi4s_tvalid && s_axi4s_tready) sent++;
      tick();
    end
    check("strm_rcvd", rcvd, 20);
    check("strm_sent", sent, 20);
    m_axi4s_tready = 1'b1;
    s_axi4s_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("strm_no_dup", m_axi4s_tvalid, 1'b0);

    // Reset mid-flight drops the in-flight beat.
    s_axi4s_tdata  = votes(zero_d, 6, 7);
    s_axi4s_tvalid = 1'b1;
    tick();
    s_axi4s_tvalid = 1'b0;
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    seen_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen_vld = seen_vld | m_axi4s_tvalid;
    end
    check("midrst_discard", seen_vld, 1'b0);

`ifdef VIDEO_DNN_CLASS_ARGMAX_HIST_EN
    // Frame: 8 beats of class 1 (first carries tuser), 4 "none", then next frame start.
    d = votes(zero_d, 1, 6);
    send_beat(d, 1'b1, 1'b0, lat);
    for (int i = 0; i < 7; i++) send_beat(d, 1'b0, 1'b0, lat);
    for (int i = 0; i < 4; i++) send_beat(votes(zero_d, 4, 2), 1'b0, 1'b0, lat);
    send_beat(d, 1'b1, 1'b0, lat);
    check("hist_pre_valid", m_hist_valid, 1'b0);
    tick();
    exp_h = '0;
    exp_h[1*HW +: HW]  = 20'd8;
    exp_h[10*HW +: HW] = 20'd4;
    check("hist_valid", m_hist_valid, 1'b1);
    check("hist_data", m_hist_data, exp_h);
    tick();
    check("hist_pulse_end", m_hist_valid, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
